// File: rtl/rca12_pkg.sv
// Shared types for the 12-bit ripple-carry adder stage and its streaming accumulator.
package rca12_pkg;

   localparam int unsigned ADD_W = 12;

   typedef logic [ADD_W-1:0] add_word_t;
   typedef logic [ADD_W:0]   add_res_t;

   typedef enum logic {
      ACC = 1'b0,
      OUT = 1'b1
   } acc_state_e;

endpackage

// File: rtl/rca12_stream_acc_if.sv
// Sample-in / adder / result-out bundle for rca12_stream_acc.
// slave = accumulator side, master = producer/adder/consumer side.
interface rca12_stream_acc_if #(
   parameter int unsigned ACC_W = 20,
   parameter int unsigned CNT_W = 5
) ();
   import rca12_pkg::*;

   logic             in_valid;
   logic             in_ready;
   add_word_t        in_data;
   logic             in_last;
   add_word_t        add_a;
   add_word_t        add_b;
   add_res_t         add_sum;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_data;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf;

   modport slave (
      input  in_valid, in_data, in_last, add_sum, out_ready,
      output in_ready, add_a, add_b, out_valid, out_data, out_count, out_ovf
   );

   modport master (
      output in_valid, in_data, in_last, add_sum, out_ready,
      input  in_ready, add_a, add_b, out_valid, out_data, out_count, out_ovf
   );

endinterface

// File: rtl/rca12_carry_inc.sv
// High-word carry incrementer for the accumulator, with wrap detect.
// Macro RCA12_STREAM_ACC_SAT_EN: on wrap clamp the whole word to all-ones
// instead of wrapping modulo 2^ACC_W.
module rca12_carry_inc
   import rca12_pkg::*;
#(
   parameter int unsigned HI_W = 8
) (
   input  logic [HI_W-1:0] i_hi,
   input  logic            i_cin,
   input  add_word_t       i_lo,
   output logic [HI_W-1:0] o_hi,
   output add_word_t       o_lo,
   output logic            o_wrap
);

   logic [HI_W:0] w_sum;

   assign w_sum  = {1'b0, i_hi} + (HI_W+1)'(i_cin);
   assign o_wrap = w_sum[HI_W];

`ifdef RCA12_STREAM_ACC_SAT_EN
   // Clamp to the full-scale value once the high word overflows.
   assign o_hi = o_wrap ? '1 : w_sum[HI_W-1:0];
   assign o_lo = o_wrap ? '1 : i_lo;
`else
   // Plain modulo wrap.
   assign o_hi = w_sum[HI_W-1:0];
   assign o_lo = i_lo;
`endif

endmodule

// File: rtl/rca12_stream_acc.sv
// Streaming block accumulator wrapped around an external 12-bit ripple-carry adder.
// Low 12 bits go through the adder, the carry feeds an internal high-word incrementer.
// Emits one block sum per BLOCK_LEN samples or per in_last, one bubble per block.
// Macro RCA12_STREAM_ACC_SAT_EN selects saturation instead of wrap on overflow.
module rca12_stream_acc #(
   parameter int unsigned ACC_W     = 20,
   parameter int unsigned BLOCK_LEN = 16
) (
   input logic               clk,
   input logic               rst_n,
   rca12_stream_acc_if.slave bus
);
   import rca12_pkg::*;

   localparam int unsigned CNT_W = $clog2(BLOCK_LEN + 1);
   localparam int unsigned HI_W  = ACC_W - ADD_W;

   acc_state_e       r_state;
   acc_state_e       w_state_nxt;
   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] w_acc_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             r_ovf;
   logic             w_ovf_nxt;
   logic [ACC_W-1:0] r_out_data;
   logic [ACC_W-1:0] w_out_data_nxt;
   logic [CNT_W-1:0] r_out_count;
   logic [CNT_W-1:0] w_out_count_nxt;
   logic             r_out_ovf;
   logic             w_out_ovf_nxt;
   logic [HI_W-1:0]  w_hi_sum;
   add_word_t        w_lo_sum;
   logic             w_wrap;
   logic             w_close;

   // Adder operands are driven straight from the accumulator and the sample.
   assign bus.add_a = r_acc[ADD_W-1:0];
   assign bus.add_b = bus.in_data;

   rca12_carry_inc #(.HI_W(HI_W)) u_carry_inc (
      .i_hi   (r_acc[ACC_W-1:ADD_W]),
      .i_cin  (bus.add_sum[ADD_W]),
      .i_lo   (bus.add_sum[ADD_W-1:0]),
      .o_hi   (w_hi_sum),
      .o_lo   (w_lo_sum),
      .o_wrap (w_wrap)
   );

   assign w_cnt_inc = r_cnt + CNT_W'(1);
   assign w_close   = (w_cnt_inc == CNT_W'(BLOCK_LEN)) || bus.in_last;

   assign bus.in_ready  = (r_state == ACC);
   assign bus.out_valid = (r_state == OUT);
   assign bus.out_data  = r_out_data;
   assign bus.out_count = r_out_count;
   assign bus.out_ovf   = r_out_ovf;

   // Next-state and next-datapath decode.
   always_comb begin
      w_state_nxt     = r_state;
      w_acc_nxt       = r_acc;
      w_cnt_nxt       = r_cnt;
      w_ovf_nxt       = r_ovf;
      w_out_data_nxt  = r_out_data;
      w_out_count_nxt = r_out_count;
      w_out_ovf_nxt   = r_out_ovf;
      case (r_state)
         ACC: begin
            if (bus.in_valid) begin
               if (w_close) begin
                  w_out_data_nxt  = {w_hi_sum, w_lo_sum};
                  w_out_count_nxt = w_cnt_inc;
                  w_out_ovf_nxt   = r_ovf | w_wrap;
                  w_acc_nxt       = '0;
                  w_cnt_nxt       = '0;
                  w_ovf_nxt       = 1'b0;
                  w_state_nxt     = OUT;
               end else begin
                  w_acc_nxt = {w_hi_sum, w_lo_sum};
                  w_cnt_nxt = w_cnt_inc;
                  w_ovf_nxt = r_ovf | w_wrap;
               end
            end
         end
         OUT: begin
            if (bus.out_ready) begin
               w_state_nxt = ACC;
            end
         end
         default: w_state_nxt = ACC;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ACC;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Accumulator and held-result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc       <= '0;
         r_cnt       <= '0;
         r_ovf       <= 1'b0;
         r_out_data  <= '0;
         r_out_count <= '0;
         r_out_ovf   <= 1'b0;
      end else begin
         r_acc       <= w_acc_nxt;
         r_cnt       <= w_cnt_nxt;
         r_ovf       <= w_ovf_nxt;
         r_out_data  <= w_out_data_nxt;
         r_out_count <= w_out_count_nxt;
         r_out_ovf   <= w_out_ovf_nxt;
      end
   end

endmodule
